simd_issue_ctrl: RTL and testbench
==================================

# simd_issue_ctrl

Instruction sequencer for the SIMD datapath. It fetches encoded vector instructions from a synchronous instruction memory and decodes each one into the load-stage control bundle. The datapath's pipeline registers capture that bundle on every advance slot (the half-rate clock phase). The block also detects read-after-write hazards against in-flight stores and inserts bubbles. It halts on a HALT opcode once the pipeline has drained.

## Interface
Parameters:
- ADDR_WIDTH, 10, BRAM word-address width.
- PC_WIDTH, 8, instruction-memory address width.
- OP_SEL_WIDTH, 2, PE operation-select width.
- Derived (localparam): INSTR_WIDTH = 4 + 3*ADDR_WIDTH. Field layout, MSB first: {opcode[3:0], r_addr, a_addr, b_addr}.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; begins execution at base_pc. Ignored while busy.
- base_pc  in  PC_WIDTH  program start address, sampled on start.
- slot  in  1  pipeline-advance strobe; high exactly when the datapath pipeline registers load.
- imem_en  out  1  instruction-memory read enable.
- imem_addr  out  PC_WIDTH  instruction-memory address.
- imem_rdata  in  INSTR_WIDTH  read data, valid the cycle after imem_en.
- a_addr, b_addr  out  ADDR_WIDTH  operand read addresses.
- pe_op  out  OP_SEL_WIDTH  PE operation.
- dot_prod_en  out  1  dot-product enable.
- shift  out  1  1 = shift dot output, 0 = accumulate.
- r_addr  out  ADDR_WIDTH  result write address.
- write_en  out  1  BRAM write enable.
- r_select  out  1  0 = PE result, 1 = dot result.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the pipeline is empty after HALT.
- stall_count  out  16  number of hazard bubbles issued in the current run; saturates at 0xFFFF.

## Operation
Opcode decode (pe_op / dot_prod_en / shift / write_en / r_select):
- 0 NOP: all control outputs 0 (bubble).
- 1 ADD: 0/0/0/1/0.
- 2 SUB: 1/0/0/1/0.
- 3 MUL: 2/0/0/1/0.
- 4 DOTS (dot, shift): 2/1/1/0/0.
- 5 DOTA (dot, accumulate): 2/1/0/0/0.
- 6 STD (store dot): 0/0/0/1/1.
- 15 HALT: issues as a bubble.
- Any other opcode: treated as NOP.
- Address outputs carry the instruction fields whenever the bundle is not a bubble; a bubble forces every output to 0.

State machine:
- IDLE: waits for start. On start: pc <= base_pc, go to FETCH.
- FETCH: drive imem_en=1, imem_addr=pc for one cycle, then go to READY.
- READY: instruction latched into the hold register.
  - On slot with no hazard: issue the instruction, pc <= pc+1, go to FETCH. pc wraps modulo 2^PC_WIDTH.
  - On slot with a hazard: issue a bubble, increment stall_count, stay in READY.
  - If the opcode is HALT: go to DRAIN on that slot; pc is not advanced.
- DRAIN: issue bubbles for 2 more slots, then go to DONE.
- DONE: pulse done for one cycle, clear busy, return to IDLE.

Hazard scoreboard:
- Two entries {valid, r_addr}, shifted on every slot. Entry 0 holds the bundle just issued; entry 1 holds the previous one.
- An entry is valid only when its bundle had write_en=1.
- Hazard: a non-bubble instruction whose a_addr or b_addr equals the r_addr of any valid entry.
- DOTS, DOTA, ADD, SUB and MUL read both operands. STD and NOP never hazard.
- Bubbles shift into the scoreboard as invalid entries.

Outputs change only on the cycle following a slot. They hold a stable value across both cycles of a slot period.

## Timing
- Reset: all control outputs 0; imem_en 0, imem_addr 0; busy 0; done 0; stall_count 0. State is IDLE, scoreboard cleared.
- rstn low mid-run aborts immediately. No done pulse is produced.
- start to first instruction issued: 2 cycles, then the first slot.
- Hazard-free throughput: one instruction per slot, since slot period ≥ 2 cycles.
- stall_count clears on accepted start.
- Simultaneous start and done: start is ignored.

## Configuration
- SIMD_HAZARD_CHECK_EN defined: scoreboard and stalling as above.
- SIMD_HAZARD_CHECK_EN undefined:
  - No scoreboard; every instruction issues on its slot.
  - stall_count is tied to 0.
  - Software inserts NOPs to avoid hazards.

## Test plan
- Run {ADD r=5 a=1 b=2; SUB r=6 a=3 b=4; HALT} at base_pc=8 with slot every 2 cycles. Expect:
  - ADD, SUB, then 3 bubbles issued;
  - imem_addr sequence 8, 9, 10;
  - done 6 slots after start;
  - stall_count 0.
- Run {MUL r=7 a=1 b=2; ADD r=8 a=7 b=3; HALT}. Expect:
  - 2 bubbles between MUL and ADD;
  - stall_count 2 (0 with the macro off, ADD issued back-to-back).
- Run {DOTS a=1 b=2; DOTA a=3 b=4; STD r=9; ADD r=10 a=9 b=0}. Expect:
  - decoded bundles exactly per the opcode decode rules;
  - ADD stalled 2 slots behind STD.
- start with base_pc=255, PC_WIDTH=8. Expect the second fetch at imem_addr 0.
- Assert rstn low during READY after 1 issue. Expect:
  - all outputs 0 next cycle;
  - busy 0;
  - no done pulse.
- Program opcode 12. Expect a bubble to be issued and pc to advance.

Source files
------------

// File: rtl/simd_issue_ctrl.sv
// simd_issue_ctrl: instruction sequencer for the SIMD datapath.
//
// Fetches {opcode, r_addr, a_addr, b_addr} words from a synchronous
// instruction memory. Each word is decoded into the load-stage control
// bundle, which is registered on every pipeline-advance slot. A slot with
// nothing ready to issue issues a bubble (all-zero bundle). Execution halts
// on HALT once two further bubble slots have drained the pipeline.
//
// Optional feature macro: SIMD_HAZARD_CHECK_EN. When defined, a two-entry
// write scoreboard stalls reads of in-flight results. When undefined, every
// instruction issues on its slot and stall_count is always 0.
//
// Ports:
//   clk, rstn             clock; synchronous active-low reset
//   start, base_pc        start pulse and program start address
//   slot                  pipeline-advance strobe
//   imem_en/addr/rdata    instruction memory read port (1-cycle latency)
//   a_addr, b_addr        operand read addresses
//   pe_op, dot_prod_en    PE operation select, dot-product enable
//   shift                 1 = shift dot output, 0 = accumulate
//   r_addr, write_en      result write address and enable
//   r_select              0 = PE result, 1 = dot result
//   busy, done            run status; done pulses once after drain
//   stall_count           hazard bubbles issued this run (saturating)
module simd_issue_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned PC_WIDTH     = 8,
  parameter int unsigned OP_SEL_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [PC_WIDTH-1:0]         base_pc,
  input  logic                        slot,
  output logic                        imem_en,
  output logic [PC_WIDTH-1:0]         imem_addr,
  input  logic [4+3*ADDR_WIDTH-1:0]   imem_rdata,
  output logic [ADDR_WIDTH-1:0]       a_addr,
  output logic [ADDR_WIDTH-1:0]       b_addr,
  output logic [OP_SEL_WIDTH-1:0]     pe_op,
  output logic                        dot_prod_en,
  output logic                        shift,
  output logic [ADDR_WIDTH-1:0]       r_addr,
  output logic                        write_en,
  output logic                        r_select,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 stall_count
);

  localparam int unsigned INSTR_WIDTH = 4 + 3*ADDR_WIDTH;

  typedef enum logic [2:0] {StIdle, StFetch, StReady, StDrain, StDone} state_e;

  typedef struct packed {
    logic [OP_SEL_WIDTH-1:0] pe_op;
    logic                    dot;
    logic                    shift;
    logic                    we;
    logic                    rsel;
    logic [ADDR_WIDTH-1:0]   r;
    logic [ADDR_WIDTH-1:0]   a;
    logic [ADDR_WIDTH-1:0]   b;
  } bundle_t;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] hold_q, hold_d;
  logic                   fresh_q, fresh_d;
  logic                   drain_q, drain_d;
  bundle_t                out_q, out_d;
  logic [15:0]            stall_q, stall_d;

  logic [INSTR_WIDTH-1:0] instr;
  logic [3:0]             opcode;
  logic [ADDR_WIDTH-1:0]  r_f, a_f, b_f;
  bundle_t                dec;
  logic                   reads;
  logic                   is_halt;
  logic                   hazard;

  // Read data is only valid the first READY cycle; afterwards use the copy.
  always_comb begin
    instr   = fresh_q ? imem_rdata : hold_q;
    opcode  = instr[INSTR_WIDTH-1 -: 4];
    r_f     = instr[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
    a_f     = instr[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    b_f     = instr[ADDR_WIDTH-1:0];
    is_halt = (opcode == 4'hF);
  end

  always_comb begin
    logic real_op;
    dec     = '0;
    reads   = 1'b0;
    real_op = 1'b1;
    case (opcode)
      4'd1: begin dec.pe_op = OP_SEL_WIDTH'(0); dec.we = 1'b1; reads = 1'b1; end
      4'd2: begin dec.pe_op = OP_SEL_WIDTH'(1); dec.we = 1'b1; reads = 1'b1; end
      4'd3: begin dec.pe_op = OP_SEL_WIDTH'(2); dec.we = 1'b1; reads = 1'b1; end
      4'd4: begin
        dec.pe_op = OP_SEL_WIDTH'(2);
        dec.dot   = 1'b1;
        dec.shift = 1'b1;
        reads     = 1'b1;
      end
      4'd5: begin dec.pe_op = OP_SEL_WIDTH'(2); dec.dot = 1'b1; reads = 1'b1; end
      4'd6: begin dec.we = 1'b1; dec.rsel = 1'b1; end
      default: real_op = 1'b0;
    endcase
    if (real_op) begin
      dec.r = r_f;
      dec.a = a_f;
      dec.b = b_f;
    end
  end

`ifdef SIMD_HAZARD_CHECK_EN
  // Entry 0 = bundle issued on the last slot, entry 1 = the one before.
  logic [1:0]                 sb_v_q;
  logic [1:0][ADDR_WIDTH-1:0] sb_r_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sb_v_q <= '0;
      sb_r_q <= '0;
    end else if (slot) begin
      sb_v_q <= {sb_v_q[0], out_d.we};
      sb_r_q <= {sb_r_q[0], out_d.r};
    end
  end

  always_comb begin
    hazard = reads &&
             ((sb_v_q[0] && (a_f == sb_r_q[0] || b_f == sb_r_q[0])) ||
              (sb_v_q[1] && (a_f == sb_r_q[1] || b_f == sb_r_q[1])));
  end
`else
  logic unused_reads;
  assign unused_reads = reads;
  assign hazard       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    fresh_d = 1'b0;
    drain_d = drain_q;
    out_d   = out_q;
    stall_d = stall_q;
    // Any slot that does not issue an instruction issues a bubble.
    if (slot) out_d = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = base_pc;
          stall_d = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        fresh_d = 1'b1;
        state_d = StReady;
      end
      StReady: begin
        hold_d = instr;
        if (slot) begin
          if (is_halt) begin
            drain_d = 1'b0;
            state_d = StDrain;
          end else if (hazard) begin
            if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
          end else begin
            out_d   = dec;
            pc_d    = pc_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDrain: begin
        if (slot) begin
          if (drain_q) state_d = StDone;
          else         drain_d = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      pc_q    <= '0;
      hold_q  <= '0;
      fresh_q <= 1'b0;
      drain_q <= 1'b0;
      out_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      fresh_q <= fresh_d;
      drain_q <= drain_d;
      out_q   <= out_d;
      stall_q <= stall_d;
    end
  end

  assign imem_en     = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign pe_op       = out_q.pe_op;
  assign dot_prod_en = out_q.dot;
  assign shift       = out_q.shift;
  assign write_en    = out_q.we;
  assign r_select    = out_q.rsel;
  assign r_addr      = out_q.r;
  assign a_addr      = out_q.a;
  assign b_addr      = out_q.b;
  assign busy        = (state_q == StFetch) || (state_q == StReady) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign stall_count = stall_q;

endmodule

// File: tb/tb_simd_issue_ctrl.sv
// Self-checking bench for simd_issue_ctrl: directed programs in a memory
// model; expected bundles and fetch addresses are queued when a run is set up
// and popped as the DUT produces them. Slot toggles every cycle (period 2).
module tb_simd_issue_ctrl;

  localparam int AW = 10;
  localparam int PW = 8;
  localparam int OW = 2;
  localparam int IW = 4 + 3*AW;

  typedef logic [35:0] bun_t;

  logic          clk = 1'b0;
  logic          rstn, start, slot;
  logic [PW-1:0] base_pc;
  logic          imem_en;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [AW-1:0] a_addr, b_addr, r_addr;
  logic [OW-1:0] pe_op;
  logic          dot_prod_en, shift, write_en, r_select, busy, done;
  logic [15:0]   stall_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [IW-1:0] mem [256];
  bun_t          exp_q[$];
  int            fetch_q[$];

  simd_issue_ctrl #(.ADDR_WIDTH(AW), .PC_WIDTH(PW), .OP_SEL_WIDTH(OW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .base_pc     (base_pc),
    .slot        (slot),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .a_addr      (a_addr),
    .b_addr      (b_addr),
    .pe_op       (pe_op),
    .dot_prod_en (dot_prod_en),
    .shift       (shift),
    .r_addr      (r_addr),
    .write_en    (write_en),
    .r_select    (r_select),
    .busy        (busy),
    .done        (done),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  function automatic bun_t mk(int pe, int dot, int sh, int we, int rs, int r, int a, int b);
    return {pe[1:0], dot[0], sh[0], we[0], rs[0], r[9:0], a[9:0], b[9:0]};
  endfunction

  function automatic logic [IW-1:0] ins(int op, int r, int a, int b);
    return {op[3:0], r[9:0], a[9:0], b[9:0]};
  endfunction

  function automatic bun_t observed();
    return {pe_op, dot_prod_en, shift, write_en, r_select, r_addr, a_addr, b_addr};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample 1 time unit after the edge, then drive next inputs.
  task automatic tick();
    logic was_slot;
    bun_t e;
    was_slot = slot;
    @(posedge clk);
    #1;
    start = 1'b0;
    slot  = ~slot;
    if (imem_en) begin
      if (fetch_q.size() > 0) chk("imem_addr", imem_addr, fetch_q.pop_front());
      else                    chk("unexpected_fetch", imem_addr, 64'hFFFF);
    end
    if (was_slot && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("bundle", observed(), e);
    end
  endtask

  // exp_q holds the start-slot bubble plus one entry per later slot.
  task automatic run(input logic [PW-1:0] b, input int exp_stall);
    int t;
    int done_tick;
    bit seen;
    done_tick = 2*exp_q.size() - 1;
    if (slot == 1'b0) tick();
    base_pc = b;
    start   = 1'b1;
    tick();
    chk("busy_after_start", busy, 1);
    t    = 1;
    seen = 1'b0;
    while (!seen && t < 200) begin
      if (done) begin
        seen = 1'b1;
        chk("done_cycle", t, done_tick);
        chk("busy_at_done", busy, 0);
        chk("stall_count", stall_count, exp_stall);
      end else begin
        tick();
        t++;
      end
    end
    if (!seen) chk("done_timeout", t, done_tick);
    tick();
    chk("done_pulse_width", done, 0);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("fetch_q_drained", fetch_q.size(), 0);
    exp_q.delete();
    fetch_q.delete();
  endtask

  initial begin
    bun_t bub;
    bit   done_seen;
    bub     = '0;
    rstn    = 1'b0;
    start   = 1'b0;
    slot    = 1'b0;
    base_pc = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    tick();
    tick();
    chk("rst_bundle", observed(), bub);
    chk("rst_imem_en", imem_en, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall_count, 0);
    rstn = 1'b1;
    tick();

    // ADD, SUB, HALT at base 8
    mem[8]  = ins(1, 5, 1, 2);
    mem[9]  = ins(2, 6, 3, 4);
    mem[10] = ins(15, 0, 0, 0);
    exp_q   = '{bub, mk(0,0,0,1,0,5,1,2), mk(1,0,0,1,0,6,3,4), bub, bub, bub};
    fetch_q = '{8, 9, 10};
    run(8'd8, 0);

    // MUL then dependent ADD
    mem[30] = ins(3, 7, 1, 2);
    mem[31] = ins(1, 8, 7, 3);
    mem[32] = ins(15, 0, 0, 0);
    fetch_q = '{30, 31, 32};
`ifdef SIMD_HAZARD_CHECK_EN
    exp_q = '{bub, mk(2,0,0,1,0,7,1,2), bub, bub, mk(0,0,0,1,0,8,7,3), bub, bub, bub};
    run(8'd30, 2);
`else
    exp_q = '{bub, mk(2,0,0,1,0,7,1,2), mk(0,0,0,1,0,8,7,3), bub, bub, bub};
    run(8'd30, 0);
`endif

    // DOTS, DOTA, STD, dependent ADD
    mem[40] = ins(4, 11, 1, 2);
    mem[41] = ins(5, 12, 3, 4);
    mem[42] = ins(6, 9, 0, 0);
    mem[43] = ins(1, 10, 9, 0);
    mem[44] = ins(15, 0, 0, 0);
    fetch_q = '{40, 41, 42, 43, 44};
`ifdef SIMD_HAZARD_CHECK_EN
    exp_q = '{bub, mk(2,1,1,0,0,11,1,2), mk(2,1,0,0,0,12,3,4), mk(0,0,0,1,1,9,0,0),
              bub, bub, mk(0,0,0,1,0,10,9,0), bub, bub, bub};
    run(8'd40, 2);
`else
    exp_q = '{bub, mk(2,1,1,0,0,11,1,2), mk(2,1,0,0,0,12,3,4), mk(0,0,0,1,1,9,0,0),
              mk(0,0,0,1,0,10,9,0), bub, bub, bub};
    run(8'd40, 0);
`endif

    // PC wrap from 255 to 0
    mem[255] = ins(1, 1, 2, 3);
    mem[0]   = ins(15, 0, 0, 0);
    exp_q    = '{bub, mk(0,0,0,1,0,1,2,3), bub, bub, bub};
    fetch_q  = '{255, 0};
    run(8'd255, 0);

    // Undefined opcode 12 issues a bubble and pc advances
    mem[20] = ins(12, 3, 3, 3);
    mem[21] = ins(1, 1, 2, 4);
    mem[22] = ins(15, 0, 0, 0);
    exp_q   = '{bub, bub, mk(0,0,0,1,0,1,2,4), bub, bub, bub};
    fetch_q = '{20, 21, 22};
    run(8'd20, 0);

    // Reset during READY after one issue
    mem[50] = ins(1, 2, 1, 3);
    mem[51] = ins(1, 4, 5, 6);
    exp_q   = '{bub, mk(0,0,0,1,0,2,1,3)};
    fetch_q = '{50, 51};
    if (slot == 1'b0) tick();
    base_pc = 8'd50;
    start   = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_abort_busy", busy, 1);
    rstn = 1'b0;
    tick();
    chk("abort_bundle", observed(), bub);
    chk("abort_imem_en", imem_en, 0);
    chk("abort_imem_addr", imem_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_stall", stall_count, 0);
    rstn      = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (done || busy) done_seen = 1'b1;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_exp_q_drained", exp_q.size(), 0);
    chk("abort_fetch_q_drained", fetch_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
